weight_load_sequencer: RTL

//  Sequences weight loading: reads 256b words from weight SRAM and drives

---
 rtl/weight_load_pkg.sv | 9 +
 rtl/rd_valid_delay.sv | 19 +
 rtl/weight_load_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/weight_load_pkg.sv
// weight_load_pkg: shared constants and FSM encoding for the weight load sequencer
package weight_load_pkg;
  localparam int NUM_IN = 81;
  localparam int NUM_OUT = 64;
  localparam int ADDR_W = 12;
  localparam int GRP_W = 8;
  localparam int RD_LAT_DEF = 2;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;
endpackage

// File: rtl/rd_valid_delay.sv
// rd_valid_delay: LAT-deep shift of the SRAM read enable, aligned with read data
//   clk, rstn : clock, async active-low clear
//   in_valid  : read enable issued this cycle
//   out_valid : read enable delayed LAT cycles (data valid at SRAM output)
module rd_valid_delay #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_valid,
  output logic out_valid
);
  logic [LAT-1:0] sr_q, sr_d;
  always_comb sr_d = (sr_q << 1) | LAT'(in_valid);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sr_q <= '0;
    else sr_q <= sr_d;
  assign out_valid = sr_q[LAT-1];
endmodule

// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer: issues whole 81-word groups from weight SRAM and counts converter outputs
//   start/cfg_base_addr/cfg_num_grp : load request and its configuration
//   stall                           : hold new reads (in-flight reads still land)
//   mem_rd_en/mem_rd_addr           : weight SRAM read port
//   cnv_valid_in/cnv_valid_out      : converter handshake
//   out_cnt/busy/done/err           : load progress, completion pulse, sticky stray-output flag
module weight_load_sequencer
  import weight_load_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int GRP_WIDTH = GRP_W,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [GRP_WIDTH-1:0]  cfg_num_grp,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  cnv_valid_in,
  input  logic                  cnv_valid_out,
  output logic [GRP_WIDTH+6:0]  out_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CW = GRP_WIDTH + 7;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [CW-1:0] tot_in_q, tot_in_d, tot_out_q, tot_out_d, issued_q, issued_d, out_cnt_q, out_cnt_d;
  logic rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0] grp;
  assign grp = CW'(cfg_num_grp);
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    addr_d = addr_q;
    tot_in_d = tot_in_q;
    tot_out_d = tot_out_q;
    issued_d = issued_q;
    rd_en_d = 1'b0;
    done_d = 1'b0;
    out_cnt_d = out_cnt_q + CW'(busy_q & cnv_valid_out);
    err_d = err_q | (state_q == S_IDLE && cnv_valid_out);
    case (state_q)
      S_IDLE: if (start) begin
        base_d = cfg_base_addr;
        // 81*n and 64*n as shift-adds, computed once per load
        tot_in_d = (grp << 6) + (grp << 4) + grp;
        tot_out_d = grp << $clog2(NUM_OUT);
        issued_d = '0;
        out_cnt_d = '0;
        err_d = 1'b0;
        state_d = (cfg_num_grp != '0) ? S_ISSUE : S_FIN;
      end
      S_ISSUE: if (!stall) begin
        rd_en_d = 1'b1;
        addr_d = base_q + ADDR_WIDTH'(issued_q);
        issued_d = issued_q + 1'b1;
        state_d = (issued_d == tot_in_q) ? S_DRAIN : S_ISSUE;
      end
      S_DRAIN: state_d = (out_cnt_q == tot_out_q) ? S_FIN : S_DRAIN;
      S_FIN: begin
        done_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      base_q <= '0;
      addr_q <= '0;
      tot_in_q <= '0;
      tot_out_q <= '0;
      issued_q <= '0;
      out_cnt_q <= '0;
      rd_en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      addr_q <= addr_d;
      tot_in_q <= tot_in_d;
      tot_out_q <= tot_out_d;
      issued_q <= issued_d;
      out_cnt_q <= out_cnt_d;
      rd_en_q <= rd_en_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  rd_valid_delay #(.LAT(RD_LAT)) u_dly (
    .clk(clk),
    .rstn(rstn),
    .in_valid(rd_en_q),
    .out_valid(cnv_valid_in)
  );
  assign mem_rd_en = rd_en_q;
  assign mem_rd_addr = addr_q;
  assign out_cnt = out_cnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule
